// File: rtl/toll_lane_ctrl.sv
// Single-lane toll-gate controller: occupancy tracking, entry-to-reader timing,
// E-pass verdict handshake and barrier commands. Define TOLL_AUTO_CLOSE_EN for the OPEN auto-close timer.
module toll_lane_ctrl #(
  parameter int CNT_W      = 4,
  parameter int MAX_VEH    = 8,
  parameter int TIME_W     = 16,
  parameter int VERIFY_TMO = 50000,
  parameter int CLOSE_TMO  = 200000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sensor_in,
  input  logic              sensor_chk,
  input  logic              sensor_out,
  input  logic              epass_valid,
  input  logic              epass_ok,
  output logic              epass_req,
  output logic [TIME_W-1:0] travel_time,
  output logic              travel_time_vld,
  output logic              gate_up,
  output logic              gate_down,
  output logic              gate_open,
  output logic              reject,
  output logic [CNT_W-1:0]  occupancy,
  output logic              lane_en,
  output logic              lane_dis,
  output logic              fault
);

  localparam int VCNT_W = (VERIFY_TMO > 1) ? $clog2(VERIFY_TMO) : 1;

  if (MAX_VEH < 1 || MAX_VEH > (2**CNT_W) - 1 || VERIFY_TMO < 1 || CLOSE_TMO < 1) begin : g_bad_param
    $error("toll_lane_ctrl: illegal parameter combination");
  end

  typedef enum logic [2:0] {S_IDLE, S_TIMING, S_VERIFY, S_OPEN, S_REJECT} state_t;

  state_t              state_q, state_d;
  logic                sin_q, sin_d, schk_q, schk_d, sout_q, sout_d;
  logic                queued_q, queued_d;
  logic [TIME_W-1:0]   timer_q, timer_d, timer_inc;
  logic [VCNT_W-1:0]   vcnt_q, vcnt_d;
  logic [CNT_W-1:0]    occ_q, occ_d;
  logic                fault_q, fault_d;
  logic [TIME_W-1:0]   travel_time_q, travel_time_d;
  logic                travel_time_vld_q, travel_time_vld_d;
  logic                epass_req_q, epass_req_d;
  logic                gate_up_q, gate_up_d, gate_down_q, gate_down_d;
  logic                gate_open_q, gate_open_d, reject_q, reject_d;
`ifdef TOLL_AUTO_CLOSE_EN
  localparam int CCNT_W = (CLOSE_TMO > 1) ? $clog2(CLOSE_TMO) : 1;
  logic [CCNT_W-1:0]   ccnt_q, ccnt_d;
`endif

  logic                entry_edge, chk_rise, chk_fall, exit_edge;
  logic                acc_entry, withdraw;
  logic [CNT_W:0]      occ_up, occ_dec;

  assign entry_edge = sensor_in & ~sin_q;
  assign chk_rise   = sensor_chk & ~schk_q;
  assign chk_fall   = ~sensor_chk & schk_q;
  assign exit_edge  = ~sensor_out & sout_q;

  assign lane_en    = (occ_q < CNT_W'(MAX_VEH));
  assign acc_entry  = entry_edge & lane_en;
  assign withdraw   = chk_fall & (state_q == S_REJECT);
  assign occ_up     = {1'b0, occ_q} + (CNT_W+1)'(acc_entry);
  assign occ_dec    = (CNT_W+1)'(exit_edge) + (CNT_W+1)'(withdraw);
  assign timer_inc  = (timer_q == '1) ? timer_q : timer_q + 1'b1;

  always_comb begin
    state_d           = state_q;
    sin_d             = sensor_in;
    schk_d            = sensor_chk;
    sout_d            = sensor_out;
    queued_d          = queued_q;
    timer_d           = timer_q;
    vcnt_d            = vcnt_q;
    fault_d           = fault_q;
    travel_time_d     = travel_time_q;
    travel_time_vld_d = 1'b0;
    epass_req_d       = 1'b0;
    gate_up_d         = 1'b0;
    gate_down_d       = 1'b0;
    gate_open_d       = gate_open_q;
    reject_d          = reject_q;
`ifdef TOLL_AUTO_CLOSE_EN
    ccnt_d            = ccnt_q;
`endif

    // Net occupancy delta; any underflow clamps at zero and flags a fault.
    if (occ_up < occ_dec) begin
      occ_d   = '0;
      fault_d = 1'b1;
    end else begin
      occ_d   = CNT_W'(occ_up - occ_dec);
    end
    if (entry_edge && !lane_en) fault_d = 1'b1;
    if (acc_entry && state_q != S_IDLE) queued_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (acc_entry || queued_q) begin
          state_d  = S_TIMING;
          timer_d  = '0;
          queued_d = 1'b0;
        end
      end
      S_TIMING: begin
        timer_d = timer_inc;
        // Capture includes the reader-edge cycle itself.
        if (chk_rise) begin
          travel_time_d     = timer_inc;
          travel_time_vld_d = 1'b1;
          epass_req_d       = 1'b1;
          vcnt_d            = '0;
          state_d           = S_VERIFY;
        end
      end
      S_VERIFY: begin
        if (epass_valid) begin
          if (epass_ok) begin
            gate_up_d   = 1'b1;
            gate_open_d = 1'b1;
            state_d     = S_OPEN;
`ifdef TOLL_AUTO_CLOSE_EN
            ccnt_d      = '0;
`endif
          end else begin
            reject_d = 1'b1;
            state_d  = S_REJECT;
          end
        end else if (vcnt_q == VCNT_W'(VERIFY_TMO - 1)) begin
          fault_d  = 1'b1;
          reject_d = 1'b1;
          state_d  = S_REJECT;
        end else begin
          vcnt_d = vcnt_q + 1'b1;
        end
      end
      S_OPEN: begin
        if (exit_edge) begin
          gate_down_d = 1'b1;
          gate_open_d = 1'b0;
          state_d     = S_IDLE;
        end
`ifdef TOLL_AUTO_CLOSE_EN
        else if (ccnt_q == CCNT_W'(CLOSE_TMO - 1)) begin
          gate_down_d = 1'b1;
          gate_open_d = 1'b0;
          fault_d     = 1'b1;
          state_d     = S_IDLE;
        end else begin
          ccnt_d = ccnt_q + 1'b1;
        end
`endif
      end
      S_REJECT: begin
        if (chk_fall) begin
          reject_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= S_IDLE;
      sin_q             <= 1'b0;
      schk_q            <= 1'b0;
      sout_q            <= 1'b0;
      queued_q          <= 1'b0;
      timer_q           <= '0;
      vcnt_q            <= '0;
      occ_q             <= '0;
      fault_q           <= 1'b0;
      travel_time_q     <= '0;
      travel_time_vld_q <= 1'b0;
      epass_req_q       <= 1'b0;
      gate_up_q         <= 1'b0;
      gate_down_q       <= 1'b0;
      gate_open_q       <= 1'b0;
      reject_q          <= 1'b0;
`ifdef TOLL_AUTO_CLOSE_EN
      ccnt_q            <= '0;
`endif
    end else begin
      state_q           <= state_d;
      sin_q             <= sin_d;
      schk_q            <= schk_d;
      sout_q            <= sout_d;
      queued_q          <= queued_d;
      timer_q           <= timer_d;
      vcnt_q            <= vcnt_d;
      occ_q             <= occ_d;
      fault_q           <= fault_d;
      travel_time_q     <= travel_time_d;
      travel_time_vld_q <= travel_time_vld_d;
      epass_req_q       <= epass_req_d;
      gate_up_q         <= gate_up_d;
      gate_down_q       <= gate_down_d;
      gate_open_q       <= gate_open_d;
      reject_q          <= reject_d;
`ifdef TOLL_AUTO_CLOSE_EN
      ccnt_q            <= ccnt_d;
`endif
    end
  end

  assign epass_req       = epass_req_q;
  assign travel_time     = travel_time_q;
  assign travel_time_vld = travel_time_vld_q;
  assign gate_up         = gate_up_q;
  assign gate_down       = gate_down_q;
  assign gate_open       = gate_open_q;
  assign reject          = reject_q;
  assign occupancy       = occ_q;
  assign lane_dis        = ~lane_en;
  assign fault           = fault_q;

endmodule

// File: tb/tb_toll_lane_ctrl.sv
// Bench for toll_lane_ctrl: occupancy vector table, directed lane scenarios and
// randomized traffic, all compared against a cycle-count based reference model.
module tb_toll_lane_ctrl;

  localparam int CNT_W      = 4;
  localparam int MAX_VEH    = 2;
  localparam int TIME_W     = 6;
  localparam int VERIFY_TMO = 8;
  localparam int CLOSE_TMO  = 16;
  localparam int TT_MAX     = (1 << TIME_W) - 1;

  localparam int P_IDLE = 0, P_TIMING = 1, P_VERIFY = 2, P_OPEN = 3, P_REJECT = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              sensor_in = 1'b0, sensor_chk = 1'b0, sensor_out = 1'b0;
  logic              epass_valid = 1'b0, epass_ok = 1'b0;
  logic              epass_req, travel_time_vld, gate_up, gate_down, gate_open;
  logic              reject, lane_en, lane_dis, fault;
  logic [TIME_W-1:0] travel_time;
  logic [CNT_W-1:0]  occupancy;

  toll_lane_ctrl #(
    .CNT_W(CNT_W), .MAX_VEH(MAX_VEH), .TIME_W(TIME_W),
    .VERIFY_TMO(VERIFY_TMO), .CLOSE_TMO(CLOSE_TMO)
  ) dut (
    .clk(clk), .reset(reset), .sensor_in(sensor_in), .sensor_chk(sensor_chk),
    .sensor_out(sensor_out), .epass_valid(epass_valid), .epass_ok(epass_ok),
    .epass_req(epass_req), .travel_time(travel_time), .travel_time_vld(travel_time_vld),
    .gate_up(gate_up), .gate_down(gate_down), .gate_open(gate_open), .reject(reject),
    .occupancy(occupancy), .lane_en(lane_en), .lane_dis(lane_dis), .fault(fault)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n_req = 0, n_up = 0, n_down = 0;

  // Reference model: lane phase plus cycle stamps of the interesting events.
  longint cyc = 0;
  int     m_phase = P_IDLE, m_occ = 0, m_tt = 0;
  bit     m_fault = 0, m_queued = 0;
  bit     m_vld = 0, m_req = 0, m_up = 0, m_down = 0;
  longint m_tstart = 0, m_vstart = 0, m_ostart = 0;
  bit     p_si = 0, p_sc = 0, p_so = 0;

  typedef struct {
    bit si, sc, so;
    int occ;
    bit en, flt;
  } vec_t;
  vec_t tbl[16];

  function automatic vec_t mk(bit si, bit sc, bit so, int occ, bit en, bit flt);
    vec_t v;
    v.si = si; v.sc = sc; v.so = so; v.occ = occ; v.en = en; v.flt = flt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit ent, cr, cf, ex, acc, wd;
    int nd, ph0;
    m_vld = 0; m_req = 0; m_up = 0; m_down = 0;
    if (reset) begin
      m_phase = P_IDLE; m_occ = 0; m_fault = 0; m_queued = 0; m_tt = 0;
      p_si = 0; p_sc = 0; p_so = 0;
      return;
    end
    ph0 = m_phase;
    ent = sensor_in && !p_si;
    cr  = sensor_chk && !p_sc;
    cf  = !sensor_chk && p_sc;
    ex  = !sensor_out && p_so;
    acc = ent && (m_occ < MAX_VEH);
    if (ent && !acc) m_fault = 1;
    wd = cf && (ph0 == P_REJECT);
    nd = m_occ + int'(acc) - int'(ex) - int'(wd);
    if (nd < 0) begin nd = 0; m_fault = 1; end
    m_occ = nd;
    if (acc && ph0 != P_IDLE) m_queued = 1;
    case (ph0)
      P_IDLE: if (acc || m_queued) begin
        m_phase = P_TIMING; m_tstart = cyc; m_queued = 0;
      end
      P_TIMING: if (cr) begin
        m_tt = (cyc - m_tstart > TT_MAX) ? TT_MAX : int'(cyc - m_tstart);
        m_vld = 1; m_req = 1; m_vstart = cyc; m_phase = P_VERIFY;
      end
      P_VERIFY: begin
        if (epass_valid) begin
          if (epass_ok) begin m_up = 1; m_phase = P_OPEN; m_ostart = cyc; end
          else m_phase = P_REJECT;
        end else if (cyc - m_vstart == VERIFY_TMO) begin
          m_fault = 1; m_phase = P_REJECT;
        end
      end
      P_OPEN: begin
        if (ex) begin m_down = 1; m_phase = P_IDLE; end
`ifdef TOLL_AUTO_CLOSE_EN
        else if (cyc - m_ostart == CLOSE_TMO) begin
          m_down = 1; m_fault = 1; m_phase = P_IDLE;
        end
`endif
      end
      P_REJECT: if (cf) m_phase = P_IDLE;
      default: m_phase = P_IDLE;
    endcase
    p_si = sensor_in; p_sc = sensor_chk; p_so = sensor_out;
  endtask

  task automatic compare_all();
    chk("m_epass_req", epass_req, m_req);
    chk("m_travel_time", travel_time, m_tt);
    chk("m_travel_vld", travel_time_vld, m_vld);
    chk("m_gate_up", gate_up, m_up);
    chk("m_gate_down", gate_down, m_down);
    chk("m_gate_open", gate_open, m_phase == P_OPEN);
    chk("m_reject", reject, m_phase == P_REJECT);
    chk("m_occupancy", occupancy, m_occ);
    chk("m_lane_en", lane_en, m_occ < MAX_VEH);
    chk("m_lane_dis", lane_dis, m_occ >= MAX_VEH);
    chk("m_fault", fault, m_fault);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    compare_all();
    n_req  += int'(epass_req);
    n_up   += int'(gate_up);
    n_down += int'(gate_down);
  endtask

  task automatic set_in(input bit si, input bit sc, input bit so, input bit ev, input bit ok);
    sensor_in = si; sensor_chk = sc; sensor_out = so; epass_valid = ev; epass_ok = ok;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_req = 0; n_up = 0; n_down = 0;
  endtask

  task automatic to_verify(input int tt);
    sensor_in = 1'b1;
    step();
    sensor_in = 1'b0;
    repeat (tt - 1) step();
    sensor_chk = 1'b1;
    step();
  endtask

  task automatic go_open(input int tt);
    to_verify(tt);
    epass_valid = 1'b1; epass_ok = 1'b1;
    step();
    epass_valid = 1'b0; epass_ok = 1'b0;
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 0, 1, 1, 0);
    tbl[1]  = mk(0, 0, 0, 1, 1, 0);
    tbl[2]  = mk(1, 0, 0, 2, 0, 0);
    tbl[3]  = mk(0, 0, 0, 2, 0, 0);
    tbl[4]  = mk(1, 0, 0, 2, 0, 1);
    tbl[5]  = mk(0, 0, 1, 2, 0, 1);
    tbl[6]  = mk(0, 0, 0, 1, 1, 1);
    tbl[7]  = mk(1, 0, 1, 2, 0, 1);
    tbl[8]  = mk(0, 0, 0, 1, 1, 1);
    tbl[9]  = mk(0, 0, 1, 1, 1, 1);
    tbl[10] = mk(1, 0, 0, 1, 1, 1);
    tbl[11] = mk(0, 0, 0, 1, 1, 1);
    tbl[12] = mk(0, 0, 1, 1, 1, 1);
    tbl[13] = mk(0, 0, 0, 0, 1, 1);
    tbl[14] = mk(0, 0, 1, 0, 1, 1);
    tbl[15] = mk(0, 0, 0, 0, 1, 1);

    // Reset state
    repeat (2) step();
    do_reset();
    chk("rst_lane_en", lane_en, 1);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_gate_open", gate_open, 0);
    chk("rst_fault", fault, 0);

    // Occupancy / capacity table
    for (int i = 0; i < 16; i++) begin
      set_in(tbl[i].si, tbl[i].sc, tbl[i].so, 0, 0);
      step();
      chk($sformatf("tbl%0d_occ", i), occupancy, tbl[i].occ);
      chk($sformatf("tbl%0d_lane_en", i), lane_en, tbl[i].en);
      chk($sformatf("tbl%0d_lane_dis", i), lane_dis, !tbl[i].en);
      chk($sformatf("tbl%0d_fault", i), fault, tbl[i].flt);
    end

    // Underflow from a clean lane
    do_reset();
    sensor_out = 1'b1; step();
    sensor_out = 1'b0; step();
    chk("underflow_fault", fault, 1);
    chk("underflow_occ", occupancy, 0);

    // Normal pass
    do_reset();
    sensor_in = 1'b1; step();
    chk("pass_occ_in", occupancy, 1);
    repeat (9) step();
    sensor_in = 1'b0; sensor_chk = 1'b1; step();
    chk("pass_travel_time", travel_time, 10);
    chk("pass_travel_vld", travel_time_vld, 1);
    chk("pass_req", epass_req, 1);
    step();
    chk("pass_vld_width", travel_time_vld, 0);
    chk("pass_req_width", epass_req, 0);
    step();
    epass_valid = 1'b1; epass_ok = 1'b1; step();
    chk("pass_gate_up", gate_up, 1);
    chk("pass_gate_open", gate_open, 1);
    epass_valid = 1'b0; epass_ok = 1'b0; step();
    chk("pass_gate_up_width", gate_up, 0);
    chk("pass_travel_held", travel_time, 10);
    sensor_chk = 1'b0; sensor_out = 1'b1; step();
    chk("pass_open_held", gate_open, 1);
    sensor_out = 1'b0; step();
    chk("pass_gate_down", gate_down, 1);
    chk("pass_open_drop", gate_open, 0);
    chk("pass_occ_out", occupancy, 0);
    step();
    chk("pass_down_width", gate_down, 0);
    chk("pass_req_count", n_req, 1);
    chk("pass_up_count", n_up, 1);
    chk("pass_down_count", n_down, 1);

    // Reject and withdraw
    do_reset();
    to_verify(10);
    step(); step();
    epass_valid = 1'b1; epass_ok = 1'b0; step();
    chk("rej_reject", reject, 1);
    chk("rej_no_gate_up", gate_up, 0);
    epass_valid = 1'b0; step();
    chk("rej_held", reject, 1);
    chk("rej_occ_before", occupancy, 1);
    sensor_chk = 1'b0; step();
    chk("rej_withdraw_occ", occupancy, 0);
    chk("rej_cleared", reject, 0);
    chk("rej_fault", fault, 0);
    chk("rej_up_count", n_up, 0);

    // Verdict timeout
    do_reset();
    to_verify(3);
    repeat (7) step();
    chk("tmo_not_yet", reject, 0);
    step();
    chk("tmo_reject", reject, 1);
    chk("tmo_fault", fault, 1);

    // Entry while OPEN is queued and timed right after gate_down
    do_reset();
    go_open(4);
    chk("q_open", gate_open, 1);
    sensor_chk = 1'b0; sensor_in = 1'b1; step();
    chk("q_occ2", occupancy, 2);
    sensor_in = 1'b0; sensor_out = 1'b1; step();
    sensor_out = 1'b0; step();
    chk("q_gate_down", gate_down, 1);
    chk("q_occ1", occupancy, 1);
    repeat (3) step();
    sensor_chk = 1'b1; step();
    chk("q_travel_time", travel_time, 3);
    chk("q_travel_vld", travel_time_vld, 1);

    // Timer saturation, then reset while OPEN
    do_reset();
    go_open(70);
    chk("sat_travel_time", travel_time, TT_MAX);
    chk("rstopen_open", gate_open, 1);
    n_down = 0;
    reset = 1'b1; step(); reset = 1'b0;
    chk("rstopen_gate_open", gate_open, 0);
    chk("rstopen_gate_down", gate_down, 0);
    chk("rstopen_occ", occupancy, 0);
    chk("rstopen_lane_en", lane_en, 1);
    step();
    chk("rstopen_down_count", n_down, 0);

    // OPEN without an exit edge
    do_reset();
    go_open(2);
    n_down = 0;
    repeat (15) step();
    chk("close_no_early_down", n_down, 0);
    chk("close_open_held", gate_open, 1);
    step();
`ifdef TOLL_AUTO_CLOSE_EN
    chk("close_gate_down", gate_down, 1);
    chk("close_fault", fault, 1);
    chk("close_open_drop", gate_open, 0);
    chk("close_occ", occupancy, 1);
`else
    chk("close_gate_down", gate_down, 0);
    chk("close_fault", fault, 0);
    chk("close_open_held2", gate_open, 1);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) sensor_in = ~sensor_in;
      if ($urandom_range(0, 6) == 0) sensor_chk = ~sensor_chk;
      if ($urandom_range(0, 4) == 0) sensor_out = ~sensor_out;
      epass_valid = ($urandom_range(0, 3) == 0);
      epass_ok    = $urandom_range(0, 1) == 1;
      reset       = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
